// File: rtl/apb_uart_fifo.sv
// APB UART with TX/RX FIFOs, run-time baud divisor, loopback, sticky error flags and a level irq.
// Optional even parity bit on both directions: define UART_PARITY_EN.
module apb_uart_fifo #(
  parameter int DATAWIDTH  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RESET = 115200
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATAWIDTH);
  localparam logic [15:0]   BAUD_DEF = 16'(CLK_FREQ / BAUD_RESET - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH - 1);
  localparam logic [AW:0]   PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_st_t;

`ifdef UART_PARITY_EN
  localparam uart_st_t ST_AFTER_DATA = ST_PARITY;
  function automatic logic even_parity(input logic [DATAWIDTH-1:0] d);
    even_parity = ^d;
  endfunction
`else
  localparam uart_st_t ST_AFTER_DATA = ST_STOP;
`endif

  logic [4:0]  addr_s;
  logic        wr_s, rd_setup_s, rd_acc_s, tx_rst_s, rx_rst_s, tx_wr_req_s;
  logic        tx_en_r, rx_en_r, loop_r, rx_ie_r, tx_ie_r;
  logic        ovr_r, ferr_r, perr_r, drop_r;
  logic [15:0] baud_r;
  logic [31:0] rdata_s;
  logic [DATAWIDTH-1:0] tx_mem_r [FIFO_DEPTH];
  logic [DATAWIDTH-1:0] rx_mem_r [FIFO_DEPTH];
  logic [AW:0] tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r;
  logic [DATAWIDTH-1:0] tx_head_s, rx_head_s;
  logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s, tx_busy_s;
  logic        tx_push_s, tx_pop_s, tx_drop_s, rx_push_s, rx_pop_s, rx_ovr_s;
  uart_st_t    tx_st_r, rx_st_r;
  logic [15:0] tx_cnt_r, rx_cnt_r, rx_half_s;
  logic [16:0] baud_p1_s;
  logic [BW-1:0] tx_bit_r, rx_bit_r;
  logic [DATAWIDTH-1:0] tx_sh_r, rx_sh_r;
  logic        tx_r, tx_par_r, rx_push_r;
  logic        rx_in_s, rx_s1_r, rx_s2_r, rx_prev_r, rx_fall_s, rx_tick_s;
  logic        ferr_set_s, perr_set_s;
  logic        unused_s;

  assign PREADY = 1'b1;
  assign tx     = tx_r;
  assign unused_s = ^{PADDR[31:5], PWDATA[31:16], baud_p1_s[0]};

  // Bus decode, FIFO flags and handshakes between the FIFOs and the shifters
  always_comb begin
    addr_s      = PADDR[4:0];
    wr_s        = PSEL & PENABLE & PWRITE;
    rd_setup_s  = PSEL & ~PENABLE & ~PWRITE;
    rd_acc_s    = PSEL & PENABLE & ~PWRITE;
    tx_rst_s    = wr_s & (addr_s == 5'h00) & PWDATA[2];
    rx_rst_s    = wr_s & (addr_s == 5'h00) & PWDATA[3];
    tx_wr_req_s = wr_s & (addr_s == 5'h02);
    tx_full_s   = (tx_wp_r[AW] != tx_rp_r[AW]) & (tx_wp_r[AW-1:0] == tx_rp_r[AW-1:0]);
    tx_empty_s  = (tx_wp_r == tx_rp_r);
    rx_full_s   = (rx_wp_r[AW] != rx_rp_r[AW]) & (rx_wp_r[AW-1:0] == rx_rp_r[AW-1:0]);
    rx_empty_s  = (rx_wp_r == rx_rp_r);
    tx_head_s   = tx_mem_r[tx_rp_r[AW-1:0]];
    rx_head_s   = rx_mem_r[rx_rp_r[AW-1:0]];
    tx_busy_s   = (tx_st_r != ST_IDLE);
    tx_pop_s    = tx_en_r & ~tx_empty_s & ~tx_rst_s &
                  ((tx_st_r == ST_IDLE) | ((tx_st_r == ST_STOP) & (tx_cnt_r == 16'd0)));
    tx_push_s   = tx_wr_req_s & (~tx_full_s | tx_pop_s);
    tx_drop_s   = tx_wr_req_s & tx_full_s & ~tx_pop_s;
    rx_pop_s    = rd_acc_s & (addr_s == 5'h03) & ~rx_empty_s;
    rx_push_s   = rx_push_r & (~rx_full_s | rx_pop_s);
    rx_ovr_s    = rx_push_r & rx_full_s & ~rx_pop_s;
    baud_p1_s   = {1'b0, baud_r} + 17'd1;
    rx_half_s   = baud_p1_s[16:1] - 16'd1;
    rx_in_s     = loop_r ? tx_r : rx;
    rx_fall_s   = rx_prev_r & ~rx_s2_r;
    rx_tick_s   = (rx_cnt_r == 16'd0);
    ferr_set_s  = rx_en_r & (rx_st_r == ST_STOP) & rx_tick_s & ~rx_s2_r;
`ifdef UART_PARITY_EN
    perr_set_s  = rx_en_r & (rx_st_r == ST_PARITY) & rx_tick_s & (rx_s2_r != even_parity(rx_sh_r));
`else
    perr_set_s  = 1'b0;
`endif
  end

  // Register read mux, sampled into PRDATA during the read setup phase
  always_comb begin
    case (addr_s)
      5'h00:   rdata_s = {25'd0, tx_ie_r, rx_ie_r, loop_r, 2'b00, rx_en_r, tx_en_r};
      5'h01:   rdata_s = {23'd0, drop_r, perr_r, ferr_r, ovr_r, tx_busy_s,
                          rx_empty_s, rx_full_s, tx_empty_s, tx_full_s};
      5'h03:   rdata_s = rx_empty_s ? 32'h0000_0000 : 32'(rx_head_s);
      5'h04:   rdata_s = {16'h0000, baud_r};
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  // Control, divisor and sticky flags; rx_rst clears every sticky flag
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      {tx_en_r, rx_en_r, loop_r, rx_ie_r, tx_ie_r} <= 5'b00000;
      {ovr_r, ferr_r, perr_r, drop_r}              <= 4'b0000;
      baud_r <= BAUD_DEF;
    end else begin
      if (wr_s && (addr_s == 5'h00)) begin
        {tx_ie_r, rx_ie_r, loop_r} <= PWDATA[6:4];
        {rx_en_r, tx_en_r}         <= PWDATA[1:0];
      end
      if (wr_s && (addr_s == 5'h04)) begin
        baud_r <= (PWDATA[15:0] < 16'd3) ? 16'd3 : PWDATA[15:0];
      end
      if (rx_rst_s) begin
        {ovr_r, ferr_r, perr_r, drop_r} <= 4'b0000;
      end else begin
        if (rx_ovr_s)   ovr_r  <= 1'b1;
        if (ferr_set_s) ferr_r <= 1'b1;
        if (perr_set_s) perr_r <= 1'b1;
        if (tx_drop_s)  drop_r <= 1'b1;
      end
    end
  end

  // FIFO pointers; a flush wins over any push or pop in the same cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      {tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r} <= {4{PTR_ZERO}};
    end else begin
      if (tx_rst_s) begin
        tx_wp_r <= PTR_ZERO;
        tx_rp_r <= PTR_ZERO;
      end else begin
        if (tx_push_s) tx_wp_r <= tx_wp_r + PTR_ONE;
        if (tx_pop_s)  tx_rp_r <= tx_rp_r + PTR_ONE;
      end
      if (rx_rst_s) begin
        rx_wp_r <= PTR_ZERO;
        rx_rp_r <= PTR_ZERO;
      end else begin
        if (rx_push_s) rx_wp_r <= rx_wp_r + PTR_ONE;
        if (rx_pop_s)  rx_rp_r <= rx_rp_r + PTR_ONE;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge PCLK) begin
    if (tx_push_s) tx_mem_r[tx_wp_r[AW-1:0]] <= PWDATA[DATAWIDTH-1:0];
    if (rx_push_s) rx_mem_r[rx_wp_r[AW-1:0]] <= rx_sh_r;
  end

  // Registered read data and interrupt
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PRDATA <= 32'h0000_0000;
      irq    <= 1'b0;
    end else begin
      if (rd_setup_s) PRDATA <= rdata_s;
      irq <= (rx_ie_r & ~rx_empty_s) | (tx_ie_r & tx_empty_s & ~tx_busy_s);
    end
  end

  // TX shifter; tx_r shows the bit of the state held during the previous cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_st_r <= ST_IDLE;  tx_cnt_r <= 16'd0;  tx_bit_r <= {BW{1'b0}};
      tx_sh_r <= {DATAWIDTH{1'b0}};  tx_r <= 1'b1;  tx_par_r <= 1'b0;
    end else if (tx_rst_s) begin
      tx_st_r <= ST_IDLE;
      tx_r    <= 1'b1;
    end else begin
      case (tx_st_r)
        ST_IDLE: tx_r <= 1'b1;
        ST_START: tx_r <= 1'b0;
        ST_DATA: tx_r <= tx_sh_r[0];
`ifdef UART_PARITY_EN
        ST_PARITY: tx_r <= tx_par_r;
`endif
        ST_STOP: tx_r <= 1'b1;
        default: tx_r <= 1'b1;
      endcase
      if (tx_pop_s) begin
        tx_sh_r  <= tx_head_s;
        tx_cnt_r <= baud_r;
`ifdef UART_PARITY_EN
        tx_par_r <= even_parity(tx_head_s);
`endif
        tx_st_r  <= ST_START;
      end else if (tx_st_r == ST_IDLE) begin
        tx_st_r <= ST_IDLE;
      end else if (tx_cnt_r != 16'd0) begin
        tx_cnt_r <= tx_cnt_r - 16'd1;
      end else begin
        tx_cnt_r <= baud_r;
        case (tx_st_r)
          ST_START: begin
            tx_bit_r <= {BW{1'b0}};
            tx_st_r  <= ST_DATA;
          end
          ST_DATA: begin
            tx_sh_r <= {1'b0, tx_sh_r[DATAWIDTH-1:1]};
            if (tx_bit_r == LAST_BIT) tx_st_r <= ST_AFTER_DATA;
            else tx_bit_r <= tx_bit_r + {{(BW-1){1'b0}}, 1'b1};
          end
`ifdef UART_PARITY_EN
          ST_PARITY: tx_st_r <= ST_STOP;
`endif
          default: tx_st_r <= ST_IDLE;
        endcase
      end
    end
  end

  // RX synchroniser and edge history
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      {rx_s1_r, rx_s2_r, rx_prev_r} <= 3'b111;
    end else begin
      {rx_s1_r, rx_s2_r, rx_prev_r} <= {rx_in_s, rx_s1_r, rx_s2_r};
    end
  end

  // RX shifter: mid-bit sampling, push requested one cycle after the stop sample
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_st_r <= ST_IDLE;  rx_cnt_r <= 16'd0;  rx_bit_r <= {BW{1'b0}};
      rx_sh_r <= {DATAWIDTH{1'b0}};  rx_push_r <= 1'b0;
    end else if (rx_rst_s || !rx_en_r) begin
      rx_st_r   <= ST_IDLE;
      rx_push_r <= 1'b0;
    end else begin
      rx_push_r <= 1'b0;
      if (rx_st_r == ST_IDLE) begin
        if (rx_fall_s) begin
          rx_cnt_r <= rx_half_s;
          rx_st_r  <= ST_START;
        end
      end else if (!rx_tick_s) begin
        rx_cnt_r <= rx_cnt_r - 16'd1;
      end else begin
        rx_cnt_r <= baud_r;
        case (rx_st_r)
          ST_START: begin
            rx_bit_r <= {BW{1'b0}};
            rx_st_r  <= rx_s2_r ? ST_IDLE : ST_DATA;
          end
          ST_DATA: begin
            rx_sh_r <= {rx_s2_r, rx_sh_r[DATAWIDTH-1:1]};
            if (rx_bit_r == LAST_BIT) rx_st_r <= ST_AFTER_DATA;
            else rx_bit_r <= rx_bit_r + {{(BW-1){1'b0}}, 1'b1};
          end
`ifdef UART_PARITY_EN
          ST_PARITY: rx_st_r <= ST_STOP;
`endif
          ST_STOP: begin
            rx_push_r <= 1'b1;
            rx_st_r   <= ST_IDLE;
          end
          default: rx_st_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo at default parameters (8-bit data, 8-deep FIFOs, parity off).
module tb_apb_uart_fifo;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic        rx, tx, irq;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] rd;
  logic [9:0]  frame_bits;
  logic [9:0]  ext_bits;

  apb_uart_fifo dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    data = PRDATA;
  endtask

  initial begin
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
    rx = 1'b1; PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Reset state
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pready", {31'd0, PREADY}, 32'h1);
    check("rst_tx", {31'd0, tx}, 32'h1);
    check("rst_irq", {31'd0, irq}, 32'h0);
    apb_read(32'h01, rd); check("rst_status", rd, 32'h00A);
    apb_read(32'h04, rd); check("rst_bauddiv", rd, 32'd867);
    apb_read(32'h00, rd); check("rst_ctrl", rd, 32'h0);

    // Divisor clamp, then single loopback frame with bit-level timing
    apb_write(32'h04, 32'd1);
    apb_read(32'h04, rd); check("baud_clamp", rd, 32'd3);
    apb_write(32'h04, 32'd9);
    apb_read(32'h04, rd); check("baud_9", rd, 32'd9);
    apb_write(32'h00, 32'h13);
    apb_read(32'h00, rd); check("ctrl_13", rd, 32'h13);
    apb_write(32'h02, 32'hA5);
    @(negedge PCLK); check("tx_pre_fall", {31'd0, tx}, 32'h1);
    @(negedge PCLK); check("tx_fall", {31'd0, tx}, 32'h0);
    frame_bits = {1'b1, 8'hA5, 1'b0};
    repeat (5) @(negedge PCLK);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), {31'd0, tx}, {31'd0, frame_bits[i]});
      repeat (10) @(negedge PCLK);
    end
    repeat (20) @(negedge PCLK);
    apb_read(32'h01, rd); check("lb_status_pending", rd, 32'h002);
    apb_read(32'h03, rd); check("lb_rxdata", rd, 32'hA5);
    apb_read(32'h01, rd); check("lb_status_empty", rd, 32'h00A);

    // TX FIFO overflow with TX disabled, then drain through loopback
    apb_write(32'h00, 32'h12);
    for (int i = 1; i <= 9; i++) apb_write(32'h02, 32'(i));
    apb_read(32'h01, rd); check("txfull_drop", rd, 32'h109);
    apb_write(32'h00, 32'h13);
    repeat (850) @(negedge PCLK);
    apb_read(32'h01, rd); check("drain_status", rd, 32'h106);
    for (int i = 1; i <= 8; i++) begin
      apb_read(32'h03, rd); check($sformatf("drain_rx%0d", i), rd, 32'(i));
    end
    apb_read(32'h01, rd); check("drain_done", rd, 32'h10A);

    // RX overrun: nine characters with no reads
    apb_write(32'h00, 32'h1B);
    apb_read(32'h00, rd); check("ctrl_selfclear", rd, 32'h13);
    apb_read(32'h01, rd); check("rxrst_flags", rd, 32'h00A);
    for (int i = 1; i <= 9; i++) apb_write(32'h02, 32'(i));
    repeat (1000) @(negedge PCLK);
    apb_read(32'h01, rd); check("ovr_status", rd, 32'h026);
    for (int i = 1; i <= 8; i++) begin
      apb_read(32'h03, rd); check($sformatf("ovr_rx%0d", i), rd, 32'(i));
    end
    apb_read(32'h03, rd); check("ovr_rx_empty_read", rd, 32'h0);
    apb_read(32'h01, rd); check("ovr_status_after", rd, 32'h02A);

    // External rx: 0x3C with a low stop bit, then a short glitch
    apb_write(32'h00, 32'h0B);
    apb_read(32'h01, rd); check("ext_clean", rd, 32'h00A);
    ext_bits = {1'b0, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = ext_bits[i];
      repeat (10) @(negedge PCLK);
    end
    rx = 1'b1;
    repeat (30) @(negedge PCLK);
    apb_read(32'h01, rd); check("ferr_status", rd, 32'h042);
    apb_read(32'h03, rd); check("ferr_rxdata", rd, 32'h3C);
    rx = 1'b0;
    repeat (3) @(negedge PCLK);
    rx = 1'b1;
    repeat (50) @(negedge PCLK);
    apb_read(32'h01, rd); check("glitch_nopush", rd, 32'h04A);

    // Interrupts, then rx_rst with a character pending
    apb_write(32'h00, 32'h33);
    check("irq_idle", {31'd0, irq}, 32'h0);
    apb_write(32'h02, 32'h5A);
    repeat (130) @(negedge PCLK);
    check("irq_rx", {31'd0, irq}, 32'h1);
    apb_read(32'h03, rd); check("irq_rxdata", rd, 32'h5A);
    @(negedge PCLK);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    apb_write(32'h00, 32'h53);
    @(negedge PCLK);
    check("irq_tx_empty", {31'd0, irq}, 32'h1);
    apb_write(32'h00, 32'h13);
    apb_write(32'h02, 32'h77);
    repeat (130) @(negedge PCLK);
    check("irq_masked", {31'd0, irq}, 32'h0);
    apb_read(32'h01, rd); check("pending_sticky", rd, 32'h042);
    apb_write(32'h00, 32'h1B);
    apb_read(32'h01, rd); check("rxrst_clear", rd, 32'h00A);
    apb_read(32'h03, rd); check("rxrst_rxdata", rd, 32'h0);
    apb_read(32'h05, rd); check("unmapped", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_uart_fifo.md
# apb_uart_fifo

APB-attached UART with parametrised data width and TX/RX FIFO depth, a run-time programmable baud divisor, an internal loopback mode, sticky error flags and a level interrupt. It is the successor of the single-buffer APB UART, keeping its register map at addresses 0x00–0x03 and adding a divisor register at 0x04. It sits on the peripheral APB bus with one `tx`/`rx` pin pair.

## Interface
- `DATAWIDTH`, 8: bits per character (5–9).
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, ≥2.
- `CLK_FREQ`, 100_000_000: PCLK frequency in Hz.
- `BAUD_RESET`, 115200: baud rate that sets the BAUDDIV reset value.
- `PCLK` in 1: clock; all logic is on the rising edge.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `PADDR` in 32: register index; only PADDR[4:0] is decoded.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB control.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data (registered).
- `PREADY` out 1: tied to 1; no wait states.
- `rx` in 1: serial input, asynchronous to PCLK.
- `tx` out 1: serial output; idles at 1.
- `irq` out 1: level interrupt.

## Operation
- Register map, by PADDR[4:0]; unmapped addresses read 0 and ignore writes:
  - 0x00 CTRL (RW):
    - [0] tx_en, [1] rx_en.
    - [2] tx_rst and [3] rx_rst: self-clearing, each reads 0. A write of 1 flushes that FIFO and aborts its shifter; rx_rst also clears the sticky error flags.
    - [4] loopback, [5] rx_ie, [6] tx_ie.
  - 0x01 STATUS (RO):
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy.
    - Sticky flags: [5] rx_overrun, [6] frame_err, [7] parity_err, [8] tx_drop.
  - 0x02 TXDATA: a write pushes PWDATA[DATAWIDTH-1:0]. A write while tx_full is dropped and sets tx_drop. Reads return 0.
  - 0x03 RXDATA: a read pops and returns the head, zero-extended. A read while empty returns 0 and does not pop.
  - 0x04 BAUDDIV (RW) [15:0]: clocks per bit minus 1. Reset value is CLK_FREQ/BAUD_RESET−1. Values below 3 are clamped to 3.
- APB transfers:
  - Writes take effect on the access-phase edge (PSEL & PENABLE & PWRITE).
  - For reads, PRDATA is loaded on the setup-phase edge (PSEL & !PENABLE & !PWRITE) and holds until the next read setup.
  - The RX pop happens on the access-phase edge.
- TX frame:
  - Sequence: start bit 0, then DATAWIDTH data bits LSB first, then the optional parity bit, then one stop bit 1.
  - Each bit lasts BAUDDIV+1 clocks.
  - States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- RX path:
  - 2-flop synchroniser. In loopback the receiver input is `tx` and external `rx` is ignored; `tx` still drives the pin.
  - A falling edge in IDLE starts a frame; the receiver samples at the bit middle, (BAUDDIV+1)/2 clocks after the edge.
  - A start bit that reads 1 at mid-bit is a false start: return to IDLE and push nothing.
  - Data is sampled every BAUDDIV+1 clocks. A stop bit of 0 sets frame_err, but the character is still pushed.
  - RX states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- `irq` = (rx_ie & !rx_empty) | (tx_ie & tx_empty & !tx_busy).
- Boundary behaviour:
  - A character completing while rx_full is discarded and sets rx_overrun; FIFO contents are unchanged.
  - A simultaneous push and pop on either FIFO performs both; the count is unchanged, including when full.
  - Read and write pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
  - Clearing tx_en mid-frame lets the current frame finish, then TX holds in IDLE.
  - Clearing rx_en mid-frame aborts to IDLE immediately, with no push.
  - Writing BAUDDIV mid-frame takes effect at the next bit boundary.

## Timing
- Reset values: tx=1, PRDATA=0, PREADY=1, irq=0, CTRL=0, STATUS shows both FIFOs empty, BAUDDIV at its default, both FSMs in IDLE.
- TXDATA write with TX idle and tx_en=1: `tx` falls 2 PCLK cycles after the access-phase edge (one cycle FIFO write, one cycle pop/load).
- tx_busy is high from the START state through the end of STOP.
- Back-to-back characters: START follows STOP with no idle bit.
- RX push occurs 1 cycle after the mid-stop-bit sample; rx_empty deasserts on the following cycle.

## Configuration
- `UART_PARITY_EN` defined:
  - An even parity bit is appended after the data bits on TX.
  - RX checks that bit; a mismatch sets parity_err, and the character is still pushed.
- `UART_PARITY_EN` undefined:
  - There is no PARITY state in either FSM.
  - STATUS[7] reads 0.

## Test plan
- Reset → STATUS reads 0x00A (both FIFOs empty), BAUDDIV reads 867 at default parameters, tx=1, irq=0.
- Set BAUDDIV=9, CTRL=0x13 (tx_en, rx_en, loopback), write TXDATA 0xA5 → `tx` carries 0,1,0,1,0,0,1,0,1,1 at 10 clocks per bit; RXDATA then reads 0xA5 and rx_empty returns to 1.
- Loopback, write 9 characters 0x01..0x09 with FIFO_DEPTH=8 and tx_en=0 → the 9th write sets tx_drop; after enabling TX, eight characters 0x01..0x08 are received.
- Without reading, receive 9 characters through loopback → rx_full=1, rx_overrun=1; eight reads return 0x01..0x08 and a ninth read returns 0.
- External `rx` with a stop bit driven low on 0x3C → RXDATA reads 0x3C and frame_err=1. A 3-clock low glitch on `rx` → no push.
- Set rx_ie=1 with a character pending → irq=1; the pop clears irq. Writing rx_rst clears the FIFO and all sticky flags.
